ref_clk_divider: RTL and testbench
==================================

// Module: ref_clk_divider
// PURPOSE
//  Digital reference-clock divider downstream of the ref-clock select decoder.
//  - Consumes the decoder's one-hot tgate_control word.
//  - Divides clk by 32/64/128/256/512 to give a 50%-duty ref_clk_out.
//  - Ratio changes are glitch-free: they apply only at output-period boundaries, so no runt pulses.
// PARAMETERS
//  SYNC_STAGES  2  flop stages resynchronising tgate_control into clk domain (>=2)
//  DEFAULT_IDX  1  index applied at reset and on invalid select (1 -> /256)
// PORTS
//  clk            in   1  divider input clock
//  rstn           in   1  asynchronous active-low reset
//  en             in   1  run request; sampled every clk
//  tgate_control  in   5  one-hot select; bit i -> ratio N=512>>i ({32,64,128,256,512} = bits 4..0)
//  ref_clk_out    out  1  divided clock, registered, 50% duty
//  period_strobe  out  1  1-cycle pulse coincident with each ref_clk_out rising edge
//  active_sel     out  5  one-hot ratio currently being generated
//  update_pending out  1  requested ratio differs from active_sel while running
//  sel_err        out  1  synchronised tgate_control not exactly one-hot
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain.
//  - rstn low asynchronously forces all flops to reset values, including mid-period.
//  Reset values:
//  - ref_clk_out=0, period_strobe=0, active_sel=5'b00010, update_pending=0, sel_err=0.
//  - Sync chain flops reset to 5'b00010. State=IDLE, cnt=0.
//  Select path:
//  - tgate_control passes through SYNC_STAGES flops -> sync_sel.
//  - sync_sel valid iff popcount==1; then req_idx = set-bit index, else req_idx = DEFAULT_IDX.
//  - sel_err <= !valid, registered; asserts SYNC_STAGES+1 cycles after input change.
//  Divider:
//  - Half period H = 256>>idx (idx 0..4 -> 256..16); cnt is 8 bits.
//  - Terminal count is cnt==H-1; no arithmetic wrap beyond that.
//  FSM states IDLE, HIGH, LOW.
//  - IDLE: ref_clk_out=0, cnt=0.
//    - If en=1: next cycle -> HIGH, active idx<=req_idx, ref_clk_out=1, period_strobe=1.
//  - HIGH: cnt++; at terminal count -> LOW, cnt<=0, ref_clk_out<=0.
//  - LOW: cnt++; at terminal count (period boundary):
//    - en=1: -> HIGH, cnt<=0, active idx<=req_idx, ref_clk_out<=1, period_strobe<=1.
//    - en=0: -> IDLE.
//  Timing and boundaries:
//  - Latency: en sampled high in IDLE at edge t -> ref_clk_out high after edge t+1.
//  - Period is exactly N clk cycles, with exactly N/2 high and N/2 low.
//  - active idx is only ever loaded at IDLE->HIGH or at the LOW->HIGH boundary.
//    A select change mid-period never alters the current period.
//  - Multiple select changes within one period: only the value present at the boundary is used.
//  - en drop mid-period: the period completes normally, then IDLE. Output is never truncated.
//  - en re-asserted before the boundary: operation continues seamlessly.
//  - update_pending = (state!=IDLE) && (req_idx!=active idx); registered.
//    Clears the cycle the new ratio loads.
//  - Simultaneous boundary and select change: the value registered in req_idx at that edge wins.
//  - active_sel = one-hot of active idx; it is never invalid.
// TESTING
//  1. Hold rstn=0 -> all outputs at reset values. Release with en=0 -> ref_clk_out stays 0 indefinitely.
//  2. tgate=5'b00001, en=1 -> 512-cycle period, 256 high/256 low; period_strobe every 512 cycles; active_sel=00001.
//  3. Running /512, change tgate to 10000 at cycle 100 of the high phase.
//     -> update_pending=1; current 512 period completes; then 32-cycle periods; no pulse <16 cycles.
//  4. tgate=5'b00110, then 5'b00000 -> sel_err=1 after SYNC_STAGES+1 cycles.
//     -> Next period is 256 cycles, active_sel=00010. Restore 01000 -> sel_err=0, /64 after boundary.
//  5. /32 running, en=0 at cycle 10 of the low phase -> low held 6 more cycles, IDLE, no strobe.
//     en=1 again -> ref_clk_out high next cycle.
//  6. rstn pulsed low during a high phase -> ref_clk_out=0 immediately.
//     On release with en=1 -> restart at /256 until the sync chain delivers the live select.

Source files
------------

// File: rtl/ref_clk_divider.sv
// Reference-clock divider: turns a one-hot ratio select into a 50%-duty clk/N output,
// switching ratio only at output-period boundaries so no runt pulses can appear.
module ref_clk_divider #(
   parameter int SYNC_STAGES = 2,
   parameter int DEFAULT_IDX = 1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [4:0] tgate_control,
   output logic       ref_clk_out,
   output logic       period_strobe,
   output logic [4:0] active_sel,
   output logic       update_pending,
   output logic       sel_err,
   output logic [1:0] dbg_state
);

   localparam logic [2:0] DEF_IDX = 3'(DEFAULT_IDX);
   localparam logic [4:0] DEF_SEL = 5'b00001 << DEF_IDX;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] sync_q [SYNC_STAGES];
   logic [4:0] sync_sel;
   logic [2:0] ones;
   logic [2:0] set_idx;
   logic       sel_valid;
   logic [2:0] req_idx_q, req_idx_d;
   logic       sel_err_q, sel_err_d;
   logic       en_q;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] term_cnt;
   logic       cnt_done;
   logic [2:0] act_idx_q, act_idx_d;
   logic       ref_q, ref_d;
   logic       strobe_q, strobe_d;
   logic       upd_q, upd_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= DEF_SEL;
      end else begin
         sync_q[0] <= tgate_control;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync_sel = sync_q[SYNC_STAGES-1];

   // Invalid (zero or multi-hot) selects fall back to the default ratio.
   always_comb begin
      ones    = '0;
      set_idx = DEF_IDX;
      for (int i = 0; i < 5; i++) begin
         if (sync_sel[i]) begin
            ones    = ones + 3'd1;
            set_idx = 3'(i);
         end
      end
      sel_valid = (ones == 3'd1);
      req_idx_d = sel_valid ? set_idx : DEF_IDX;
      sel_err_d = !sel_valid;
   end

   assign term_cnt = 8'hFF >> act_idx_q;
   assign cnt_done = (cnt_q == term_cnt);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_idx_d = act_idx_q;
      ref_d     = ref_q;
      strobe_d  = 1'b0;
      case (state_q)
         IDLE: begin
            ref_d = 1'b0;
            cnt_d = '0;
            if (en_q) begin
               state_d   = HIGH;
               act_idx_d = req_idx_q;
               ref_d     = 1'b1;
               strobe_d  = 1'b1;
            end
         end
         HIGH: begin
            if (cnt_done) begin
               state_d = LOW;
               cnt_d   = '0;
               ref_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         LOW: begin
            // Period boundary: the only place besides IDLE where a new ratio loads.
            if (cnt_done) begin
               cnt_d = '0;
               if (en_q) begin
                  state_d   = HIGH;
                  act_idx_d = req_idx_q;
                  ref_d     = 1'b1;
                  strobe_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            ref_d   = 1'b0;
         end
      endcase
      upd_d = (state_d != IDLE) && (req_idx_d != act_idx_d);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         act_idx_q <= DEF_IDX;
         ref_q     <= 1'b0;
         strobe_q  <= 1'b0;
         upd_q     <= 1'b0;
         req_idx_q <= DEF_IDX;
         sel_err_q <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         act_idx_q <= act_idx_d;
         ref_q     <= ref_d;
         strobe_q  <= strobe_d;
         upd_q     <= upd_d;
         req_idx_q <= req_idx_d;
         sel_err_q <= sel_err_d;
         en_q      <= en;
      end
   end

   assign ref_clk_out    = ref_q;
   assign period_strobe  = strobe_q;
   assign active_sel     = 5'b00001 << act_idx_q;
   assign update_pending = upd_q;
   assign sel_err        = sel_err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_ref_clk_divider.sv
// Bench for ref_clk_divider: directed select/enable/reset sequences, with a period
// monitor checking each output period against an expected {active_sel, half_period} queue.
module tb_ref_clk_divider;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd2;

   logic       clk;
   logic       rstn;
   logic       en;
   logic [4:0] tgate_control;
   logic       ref_clk_out;
   logic       period_strobe;
   logic [4:0] active_sel;
   logic       update_pending;
   logic       sel_err;
   logic [1:0] dbg_state;

   int total;
   int bad;

   // Each entry: {expected active_sel[4:0], expected half period[8:0]}.
   logic [13:0] exp_q[$];

   ref_clk_divider #(.SYNC_STAGES(2), .DEFAULT_IDX(1)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .en             (en),
      .tgate_control  (tgate_control),
      .ref_clk_out    (ref_clk_out),
      .period_strobe  (period_strobe),
      .active_sel     (active_sel),
      .update_pending (update_pending),
      .sel_err        (sel_err),
      .dbg_state      (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_period(input logic [4:0] sel, input logic [8:0] half, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({sel, half});
   endtask

   task automatic wait_strobe(input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_strobe && n < limit);
      check("strobe_arrived", period_strobe, 1);
   endtask

   task automatic check_latency(input string name);
      @(negedge clk);
      check({name, "_lat_low"}, ref_clk_out, 0);
      @(negedge clk);
      check({name, "_lat_high"}, ref_clk_out, 1);
   endtask

   // Monitor: measures every output period and compares it with the queue head.
   int          phase;
   int          high_cnt;
   int          low_cnt;
   logic [8:0]  cur_half;
   logic [13:0] ent;

   initial begin
      phase    = 0;
      high_cnt = 0;
      low_cnt  = 0;
      cur_half = '0;
   end

   always @(negedge clk) begin
      if (!rstn) begin
         phase = 0;
      end else if (period_strobe) begin
         if (phase == 2) check("low_len", low_cnt, cur_half);
         check("strobe_expected", exp_q.size() > 0, 1);
         check("strobe_with_rise", ref_clk_out, 1);
         if (exp_q.size() > 0) begin
            ent      = exp_q.pop_front();
            cur_half = ent[8:0];
            check("period_sel", active_sel, ent[13:9]);
         end
         phase    = 1;
         high_cnt = 1;
      end else if (phase == 1) begin
         if (ref_clk_out) begin
            high_cnt++;
         end else begin
            check("high_len", high_cnt, cur_half);
            phase   = 2;
            low_cnt = 1;
         end
      end else if (phase == 2) begin
         if (dbg_state == ST_IDLE) begin
            check("low_len_before_idle", low_cnt, cur_half);
            phase = 0;
         end else if (!ref_clk_out) begin
            low_cnt++;
         end else begin
            check("rise_without_strobe", ref_clk_out, 0);
         end
      end
   end

   initial begin
      logic ok;
      int   n;
      total = 0;
      bad   = 0;
      rstn  = 1'b0;
      en    = 1'b0;
      tgate_control = 5'b00001;

      repeat (3) @(negedge clk);
      check("rst_ref", ref_clk_out, 0);
      check("rst_strobe", period_strobe, 0);
      check("rst_active_sel", active_sel, 5'b00010);
      check("rst_upd", update_pending, 0);
      check("rst_sel_err", sel_err, 0);
      check("rst_state", dbg_state, ST_IDLE);
      rstn = 1'b1;

      ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ref_clk_out || period_strobe) ok = 1'b0;
      end
      check("idle_stays_low", ok, 1);

      push_period(5'b00001, 9'd256, 2);
      push_period(5'b10000, 9'd16, 3);
      push_period(5'b00010, 9'd128, 1);
      push_period(5'b01000, 9'd32, 2);
      push_period(5'b10000, 9'd16, 2);

      en = 1'b1;
      check_latency("start");
      check("start_sel", active_sel, 5'b00001);

      wait_strobe(600);
      repeat (100) @(negedge clk);
      check("upd_before_change", update_pending, 0);
      tgate_control = 5'b10000;
      repeat (5) @(negedge clk);
      check("upd_after_change", update_pending, 1);
      check("sel_held_mid_period", active_sel, 5'b00001);

      wait_strobe(600);
      check("upd_cleared_on_load", update_pending, 0);
      wait_strobe(600);
      wait_strobe(600);

      tgate_control = 5'b00110;
      repeat (2) @(negedge clk);
      check("sel_err_not_yet", sel_err, 0);
      @(negedge clk);
      check("sel_err_set", sel_err, 1);
      @(negedge clk);
      check("upd_invalid_sel", update_pending, 1);
      check("sel_held_invalid", active_sel, 5'b10000);
      tgate_control = 5'b00000;
      repeat (4) @(negedge clk);
      check("sel_err_zero_sel", sel_err, 1);

      wait_strobe(600);
      tgate_control = 5'b01000;
      repeat (3) @(negedge clk);
      check("sel_err_cleared", sel_err, 0);
      check("upd_restore", update_pending, 1);

      wait_strobe(600);
      wait_strobe(600);
      tgate_control = 5'b10000;
      wait_strobe(600);
      wait_strobe(600);

      repeat (26) @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      check("drop_low_held_state", dbg_state, ST_LOW);
      check("drop_low_held_ref", ref_clk_out, 0);
      @(negedge clk);
      check("drop_idle_state", dbg_state, ST_IDLE);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ref_clk_out || period_strobe) ok = 1'b0;
      end
      check("drop_idle_quiet", ok, 1);

      push_period(5'b10000, 9'd16, 1);
      en = 1'b1;
      check_latency("restart");

      repeat (5) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("midrst_ref", ref_clk_out, 0);
      check("midrst_strobe", period_strobe, 0);
      check("midrst_sel", active_sel, 5'b00010);
      check("midrst_upd", update_pending, 0);
      push_period(5'b00010, 9'd128, 1);
      push_period(5'b10000, 9'd16, 2);
      @(negedge clk);
      @(negedge clk);
      #2 rstn = 1'b1;
      check_latency("post_reset");
      check("post_reset_sel", active_sel, 5'b00010);
      repeat (3) @(negedge clk);
      check("post_reset_upd", update_pending, 1);

      wait_strobe(600);
      check("live_sel_loaded", active_sel, 5'b10000);
      check("live_sel_upd", update_pending, 0);
      wait_strobe(600);
      en = 1'b0;

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dbg_state != ST_IDLE && n < 100);
      check("final_idle", dbg_state, ST_IDLE);
      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
